// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver.
//
// Receives asynchronous serial frames (start, DATA_BITS data LSB first,
// optional parity, STOP_BITS stop bits) using mid-bit sampling derived from
// the system clock. Completed words are presented on a valid/ready output;
// a frame that completes while a previous word is still unaccepted is
// dropped and flagged with a one-cycle overrun pulse.
//
// Parameters:
//   CLKS_PER_BIT  system clocks per bit period (>= 8)
//   DATA_BITS     data bits per frame (5..9)
//   PARITY        0 = none, 1 = odd, 2 = even
//   STOP_BITS     1 or 2
//
// Ports:
//   clock        system clock, rising edge
//   reset        synchronous active-high reset
//   uartRxPin    asynchronous serial input, idles high
//   data         received word (valid-qualified)
//   valid        word available, held until accepted
//   ready        consumer accepts on valid && ready
//   parityError  parity mismatch for current word (valid-qualified)
//   frameError   a stop bit was sampled low (valid-qualified)
//   overrun      one-cycle pulse: a completed frame was dropped
//   busy         receiver is not idle
//   breakDetect  (only with UART_RX_BREAK_EN) one-cycle pulse on a break
//
// Optional feature macro: UART_RX_BREAK_EN. When defined, an all-zero frame
// whose first stop sample is also low is reported on breakDetect instead of
// being delivered, and the receiver waits for the line to return high.

module uart_rx_param #(
    parameter int CLKS_PER_BIT = 104,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 uartRxPin,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    input  logic                 ready,
    output logic                 parityError,
    output logic                 frameError,
    output logic                 overrun,
`ifdef UART_RX_BREAK_EN
    output logic                 breakDetect,
`endif
    output logic                 busy
);

    localparam int            CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [3:0]    LAST_BIT  = 4'(DATA_BITS - 1);
    localparam logic          LAST_STOP = 1'(STOP_BITS - 1);
    // Required XOR of data and parity bit for a correct frame.
    localparam logic          ODD       = (PARITY == 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_DONE,
        S_WAIT_HIGH
    } state_t;

    state_t               state;
    logic                 sync1;
    logic                 rxs;
    logic [CW-1:0]        cnt;
    logic [3:0]           bit_idx;
    logic                 stop_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_err_p;
    logic                 frm_err_p;
    logic                 tick;

`ifdef UART_RX_BREAK_EN
    logic par_bit;
    logic stop0;
    logic is_break;

    assign is_break = (shreg == '0) && ((PARITY == 0) || !par_bit) && !stop0;
`endif

    assign tick = (cnt == '0);
    assign busy = (state != S_IDLE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= S_IDLE;
            sync1       <= 1'b1;
            rxs         <= 1'b1;
            cnt         <= '0;
            bit_idx     <= '0;
            stop_idx    <= 1'b0;
            shreg       <= '0;
            par_err_p   <= 1'b0;
            frm_err_p   <= 1'b0;
            data        <= '0;
            valid       <= 1'b0;
            parityError <= 1'b0;
            frameError  <= 1'b0;
            overrun     <= 1'b0;
`ifdef UART_RX_BREAK_EN
            par_bit     <= 1'b0;
            stop0       <= 1'b1;
            breakDetect <= 1'b0;
`endif
        end else begin
            sync1   <= uartRxPin;
            rxs     <= sync1;
            overrun <= 1'b0;
`ifdef UART_RX_BREAK_EN
            breakDetect <= 1'b0;
`endif
            // Plain accept; a delivery in DONE below overrides this.
            if (valid && ready) valid <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (!rxs) begin
                        state <= S_START;
                        cnt   <= HALF_LOAD;
                    end
                end

                // Mid-start sample: a high line here means the edge was noise.
                S_START: begin
                    if (tick) begin
                        if (rxs) begin
                            state <= S_IDLE;
                        end else begin
                            state     <= S_DATA;
                            cnt       <= FULL_LOAD;
                            bit_idx   <= '0;
                            par_err_p <= 1'b0;
                            frm_err_p <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end

                // LSB arrives first, so shifting in at the MSB leaves the
                // word right-aligned after DATA_BITS samples.
                S_DATA: begin
                    if (tick) begin
                        shreg <= {rxs, shreg[DATA_BITS-1:1]};
                        cnt   <= FULL_LOAD;
                        if (bit_idx == LAST_BIT) begin
                            state    <= (PARITY != 0) ? S_PARITY : S_STOP;
                            stop_idx <= 1'b0;
                        end else begin
                            bit_idx <= bit_idx + 4'd1;
                        end
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end

                S_PARITY: begin
                    if (tick) begin
                        par_err_p <= ((^shreg) ^ rxs) != ODD;
`ifdef UART_RX_BREAK_EN
                        par_bit   <= rxs;
`endif
                        cnt       <= FULL_LOAD;
                        stop_idx  <= 1'b0;
                        state     <= S_STOP;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end

                // Leave at the middle of the last stop bit so a following
                // start edge is never missed.
                S_STOP: begin
                    if (tick) begin
                        if (!rxs) frm_err_p <= 1'b1;
`ifdef UART_RX_BREAK_EN
                        if (stop_idx == 1'b0) stop0 <= rxs;
`endif
                        cnt <= FULL_LOAD;
                        if (stop_idx == LAST_STOP) begin
                            state <= S_DONE;
                        end else begin
                            stop_idx <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end

                S_DONE: begin
                    state <= S_IDLE;
`ifdef UART_RX_BREAK_EN
                    if (is_break) begin
                        breakDetect <= 1'b1;
                        state       <= S_WAIT_HIGH;
                    end else
`endif
                    if (!valid || ready) begin
                        data        <= shreg;
                        parityError <= par_err_p;
                        frameError  <= frm_err_p;
                        valid       <= 1'b1;
                    end else begin
                        overrun <= 1'b1;
                    end
                end

                S_WAIT_HIGH: begin
                    if (rxs) state <= S_IDLE;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
